// File: rtl/decode_hazard_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// decode_hazard_controller
//
// Issue controller in front of the instruction-decode stage of the 20-bit
// pipeline. It keeps a per-register scoreboard of in-flight writes, holds off
// the fetch->decode handshake on read-after-write hazards, and issues
// registered register-file addresses plus the opcode to the execute stage.
//
// Optional feature macro: FORWARDING_EN
//   defined   : EX/MEM bypass exists; only the cycle straight after a load
//               stalls a dependent instruction.
//   undefined : full WB_LATENCY-cycle interlock on every in-flight write.
//
// Ports
//   clock           in   1   rising-edge clock
//   reset           in   1   asynchronous, active-low reset
//   in_valid        in   1   fetch presents a valid instruction
//   in_instruction  in   20  [19:16] opcode, [15:12] dest, [11:8] src1, [7:4] src2
//   in_ready        out  1   combinational: decode accepts in_instruction this cycle
//   flush           in   1   drop the presented instruction this cycle
//   issue_valid     out  1   registered: issue fields valid this cycle
//   issue_opcode    out  4   opcode of issued instruction
//   ReadAddressRF1  out  4   RF read port 1 address
//   ReadAddressRF2  out  4   RF read port 2 address
//   WriteAddress    out  4   destination register (0 when no destination)
//   issue_writes    out  1   issued instruction writes WriteAddress
//   stall_count     out  16  saturating count of stalled cycles since reset
//
// Handshake: an instruction transfers on a rising edge when in_valid and
// in_ready are both high and flush is low. in_ready never depends on in_valid.
// flush forces in_ready high so fetch can move on, but the presented
// instruction is discarded rather than issued.
// -----------------------------------------------------------------------------
module decode_hazard_controller #(
    parameter int unsigned WB_LATENCY   = 3,
    parameter logic [3:0]  LOAD_OPCODE  = 4'b1011,
    parameter logic [3:0]  STORE_OPCODE = 4'b1100,
    parameter logic [3:0]  NOP_OPCODE   = 4'b0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [19:0] in_instruction,
    output logic        in_ready,
    input  logic        flush,
    output logic        issue_valid,
    output logic [3:0]  issue_opcode,
    output logic [3:0]  ReadAddressRF1,
    output logic [3:0]  ReadAddressRF2,
    output logic [3:0]  WriteAddress,
    output logic        issue_writes,
    output logic [15:0] stall_count
);

    localparam int                CNT_W    = $clog2(WB_LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WB_LATENCY);

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [3:0] dec_opcode;
    logic [3:0] dec_src1;
    logic [3:0] dec_src2;
    logic [3:0] dec_dest;
    logic       dec_use_src1;
    logic       dec_use_src2;
    logic       dec_has_dest;

    always_comb begin
        dec_opcode   = in_instruction[19:16];
        dec_src1     = in_instruction[11:8];
        dec_src2     = in_instruction[7:4];
        dec_dest     = in_instruction[15:12];
        dec_use_src1 = 1'b1;
        dec_use_src2 = 1'b1;
        dec_has_dest = 1'b1;
        if (dec_opcode == NOP_OPCODE) begin
            dec_src1     = 4'd0;
            dec_src2     = 4'd0;
            dec_dest     = 4'd0;
            dec_use_src1 = 1'b0;
            dec_use_src2 = 1'b0;
            dec_has_dest = 1'b0;
        end else if (dec_opcode == STORE_OPCODE) begin
            // Stores read the data register from the dest field slot.
            dec_src1     = in_instruction[15:12];
            dec_src2     = in_instruction[11:8];
            dec_dest     = 4'd0;
            dec_has_dest = 1'b0;
        end
    end

    // Low nibble carries no register field for this block.
    logic unused_imm;
    assign unused_imm = ^in_instruction[3:0];

    // ------------------------------------------------------------------
    // Scoreboard: cycles until each register is readable, plus whether
    // the pending write comes from a load.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] sb_cnt [16];
    logic [15:0]      sb_load;
    logic [15:0]      busy;
    logic             hazard;
    logic             fire;

    always_comb begin
        busy = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef FORWARDING_EN
            // Counter at its top value means the load issued last cycle;
            // its data is not yet on the bypass path.
            busy[i] = sb_load[i] && (sb_cnt[i] == CNT_LOAD);
`else
            busy[i] = (sb_cnt[i] != '0);
`endif
        end
    end

`ifndef FORWARDING_EN
    logic unused_load_flags;
    assign unused_load_flags = ^sb_load;
`endif

    assign hazard   = (dec_use_src1 && busy[dec_src1]) ||
                      (dec_use_src2 && busy[dec_src2]);
    assign in_ready = !hazard || flush;
    assign fire     = in_valid && in_ready && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                sb_cnt[i] <= '0;
            end
            sb_load <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                // A new write to the same register replaces the older one.
                if (fire && dec_has_dest && (dec_dest == 4'(i))) begin
                    sb_cnt[i]  <= CNT_LOAD;
                    sb_load[i] <= (dec_opcode == LOAD_OPCODE);
                end else if (sb_cnt[i] != '0) begin
                    sb_cnt[i] <= sb_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register: fields hold their last value when nothing issues.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_valid    <= 1'b0;
            issue_opcode   <= 4'd0;
            ReadAddressRF1 <= 4'd0;
            ReadAddressRF2 <= 4'd0;
            WriteAddress   <= 4'd0;
            issue_writes   <= 1'b0;
        end else begin
            issue_valid <= fire;
            if (fire) begin
                issue_opcode   <= dec_opcode;
                ReadAddressRF1 <= dec_src1;
                ReadAddressRF2 <= dec_src2;
                WriteAddress   <= dec_dest;
                issue_writes   <= dec_has_dest;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_controller.sv
`timescale 1ns/1ps
module tb_decode_hazard_controller;

  localparam int L          = 3;
  localparam int SAT_LAT    = 15;
  localparam int SAT_CYCLES = 72000;
  localparam int ISSUE_W    = 18;

  localparam logic [19:0] ADD_R1  = 20'h11230;  // r1 <- r2, r3
  localparam logic [19:0] ADD_R4  = 20'h14150;  // r4 <- r1, r5
  localparam logic [19:0] LOAD_R1 = 20'hB1230;  // r1 <- mem(r2, r3)
  localparam logic [19:0] STORE_A = 20'hC1200;  // store r1 via r2

`ifdef FORWARDING_EN
  localparam int K_ALU = 1;
  localparam int K_LOAD = 2;
  localparam int K_FLUSH = 1;
  localparam logic STORE_RDY = 1'b1;
`else
  localparam int K_ALU = 4;
  localparam int K_LOAD = 4;
  localparam int K_FLUSH = 3;
  localparam logic STORE_RDY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid;
  logic [19:0] in_instruction;
  logic        in_ready;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic [3:0]  ReadAddressRF1;
  logic [3:0]  ReadAddressRF2;
  logic [3:0]  WriteAddress;
  logic        issue_writes;
  logic [15:0] stall_count;

  decode_hazard_controller #(.WB_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_instruction(in_instruction),
    .in_ready(in_ready), .flush(flush), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .ReadAddressRF1(ReadAddressRF1), .ReadAddressRF2(ReadAddressRF2),
    .WriteAddress(WriteAddress), .issue_writes(issue_writes), .stall_count(stall_count)
  );

  // Second instance with a long latency so the saturating counter is reachable.
  logic        s_reset;
  logic        s_in_ready;
  logic        s_issue_valid;
  logic [3:0]  s_issue_opcode;
  logic [3:0]  s_ra1;
  logic [3:0]  s_ra2;
  logic [3:0]  s_wa;
  logic        s_issue_writes;
  logic [15:0] s_stall_count;

  decode_hazard_controller #(.WB_LATENCY(SAT_LAT)) u_sat (
    .clock(clock), .reset(s_reset), .in_valid(1'b1), .in_instruction(20'h11110),
    .in_ready(s_in_ready), .flush(1'b0), .issue_valid(s_issue_valid), .issue_opcode(s_issue_opcode),
    .ReadAddressRF1(s_ra1), .ReadAddressRF2(s_ra2),
    .WriteAddress(s_wa), .issue_writes(s_issue_writes), .stall_count(s_stall_count)
  );

  // ---------------- scoreboard state ----------------
  int vec_count = 0;
  int miscompares = 0;
  logic [ISSUE_W-1:0] exp_q[$];

  // Reference model: time stamps instead of counters.
  int          cyc;
  int          free_cyc[16];   // first cycle the register is readable again
  int          load_cyc[16];   // cycle in which a load result is not yet bypassable
  logic [16:0] last_fields;
  int          stall_m;
  logic        rdy_seen;
  logic        sat_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    stall_m = 0;
    last_fields = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      free_cyc[i] = 0;
      load_cyc[i] = -1;
    end
  endtask

  function automatic bit busy_m(input logic [3:0] r);
`ifdef FORWARDING_EN
    return load_cyc[r] == cyc;
`else
    return cyc < free_cyc[r];
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b0;
    in_valid = 1'b1;
    in_instruction = ADD_R1;
    flush = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_issue", 32'({issue_valid, issue_opcode, ReadAddressRF1, ReadAddressRF2,
                          WriteAddress, issue_writes}), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic drive_cycle(input logic v, input logic [19:0] ins, input logic fl);
    logic [3:0] op, s1, s2, d;
    bit us1, us2, hd, haz, rdy, fire;
    logic [ISSUE_W-1:0] exp_v, got;
    in_valid = v;
    in_instruction = ins;
    flush = fl;
    #1;
    op = ins[19:16];
    if (op == 4'h0) begin
      s1 = 0; s2 = 0; d = 0; us1 = 0; us2 = 0; hd = 0;
    end else if (op == 4'hC) begin
      s1 = ins[15:12]; s2 = ins[11:8]; d = 0; us1 = 1; us2 = 1; hd = 0;
    end else begin
      s1 = ins[11:8]; s2 = ins[7:4]; d = ins[15:12]; us1 = 1; us2 = 1; hd = 1;
    end
    haz = (us1 && busy_m(s1)) || (us2 && busy_m(s2));
    rdy = !haz || fl;
    fire = v && rdy && !fl;
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (v && !rdy && stall_m < 65535) stall_m++;
    if (fire) begin
      if (hd) begin
        free_cyc[d] = cyc + L + 1;
        load_cyc[d] = (op == 4'hB) ? cyc + 1 : -1;
      end
      last_fields = {op, s1, s2, d, hd};
    end
    exp_q.push_back({fire, last_fields});
    @(posedge clock); #1;
    cyc++;
    exp_v = exp_q.pop_front();
    got = {issue_valid, issue_opcode, ReadAddressRF1, ReadAddressRF2, WriteAddress, issue_writes};
    chk("issue", 32'(got), 32'(exp_v));
    chk("stall_count", 32'(stall_count), 32'(stall_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 20'h0, 1'b0);
  endtask

  // Present one instruction until it issues; k = cycles taken, 0 if never.
  task automatic wait_issue(input logic [19:0] ins, input int max, output int k, output logic first_rdy);
    k = 0;
    first_rdy = 1'b0;
    for (int i = 1; i <= max; i++) begin
      drive_cycle(1'b1, ins, 1'b0);
      if (i == 1) first_rdy = rdy_seen;
      if (issue_valid) begin
        k = i;
        break;
      end
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [19:0] instr;
    logic [3:0]  op;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa;
    logic        wr;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- saturation run ----------------
  initial begin : sat_proc
    int sc;
    int sfree;
    int sstall;
    s_reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("sat_rst_stall_count", 32'(s_stall_count), 32'd0);
    s_reset = 1'b1;
    sc = 0;
    sfree = 0;
    sstall = 0;
    for (int i = 0; i < SAT_CYCLES; i++) begin
`ifndef FORWARDING_EN
      if (sc < sfree) sstall++;
      else sfree = sc + SAT_LAT + 1;
`endif
      @(posedge clock); #1;
      sc++;
      if (i == 999 || i == 60000 || i == SAT_CYCLES - 1)
        chk("sat_stall_count", 32'(s_stall_count), 32'(sstall > 65535 ? 65535 : sstall));
    end
    sat_done = 1'b1;
  end

  // ---------------- main test ----------------
  initial begin : main_proc
    int k;
    logic fr;
    logic [3:0] ops[6];
    logic [3:0] op;
    reset = 1'b0;
    in_valid = 1'b0;
    in_instruction = '0;
    flush = 1'b0;

    vecs[0] = '{20'h11230, 4'h1, 4'h2, 4'h3, 4'h1, 1'b1};
    vecs[1] = '{20'hC1200, 4'hC, 4'h1, 4'h2, 4'h0, 1'b0};
    vecs[2] = '{20'h0ABCD, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[3] = '{20'hB5670, 4'hB, 4'h6, 4'h7, 4'h5, 1'b1};
    vecs[4] = '{20'hFEDC9, 4'hF, 4'hD, 4'hC, 4'hE, 1'b1};
    vecs[5] = '{20'hCFE00, 4'hC, 4'hF, 4'hE, 4'h0, 1'b0};

    // Reset with in_valid high, then first instruction issues next cycle.
    apply_reset();
    drive_cycle(1'b1, ADD_R1, 1'b0);
    chk("first_issue_valid", 32'(issue_valid), 32'd1);

    // Decode table on a drained scoreboard.
    idle(L + 1);
    foreach (vecs[i]) begin
      drive_cycle(1'b1, vecs[i].instr, 1'b0);
      chk("tbl_issue", 32'({issue_valid, issue_opcode, ReadAddressRF1, ReadAddressRF2,
                            WriteAddress, issue_writes}),
          32'({1'b1, vecs[i].op, vecs[i].ra1, vecs[i].ra2, vecs[i].wa, vecs[i].wr}));
      idle(L + 1);
      chk("tbl_hold_valid", 32'(issue_valid), 32'd0);
      chk("tbl_hold_op", 32'(issue_opcode), 32'(vecs[i].op));
    end

    // Back-to-back ALU RAW.
    apply_reset();
    drive_cycle(1'b1, ADD_R1, 1'b0);
    wait_issue(ADD_R4, 10, k, fr);
    chk("raw_alu_latency", 32'(k), 32'(K_ALU));
    chk("raw_alu_stalls", 32'(stall_count), 32'(K_ALU - 1));

    // Load-use.
    apply_reset();
    drive_cycle(1'b1, LOAD_R1, 1'b0);
    wait_issue(ADD_R4, 10, k, fr);
    chk("load_use_latency", 32'(k), 32'(K_LOAD));
    chk("load_use_stalls", 32'(stall_count), 32'(K_LOAD - 1));

    // Store reading the dest-field register.
    apply_reset();
    drive_cycle(1'b1, ADD_R1, 1'b0);
    wait_issue(STORE_A, 10, k, fr);
    chk("store_first_ready", 32'(fr), 32'(STORE_RDY));
    chk("store_latency", 32'(k), 32'(K_ALU));
    chk("store_writes", 32'({issue_writes, WriteAddress, ReadAddressRF1, ReadAddressRF2}),
        32'({1'b0, 4'h0, 4'h1, 4'h2}));

    // Flush while stalled.
    apply_reset();
    drive_cycle(1'b1, ADD_R1, 1'b0);
    drive_cycle(1'b1, ADD_R4, 1'b1);
    chk("flush_ready", 32'(rdy_seen), 32'd1);
    chk("flush_issue_valid", 32'(issue_valid), 32'd0);
    wait_issue(ADD_R4, 10, k, fr);
    chk("flush_resume_latency", 32'(k), 32'(K_FLUSH));

    // WAW: load overwrites a decrementing ALU entry.
    apply_reset();
    drive_cycle(1'b1, ADD_R1, 1'b0);
    idle(2);
    drive_cycle(1'b1, LOAD_R1, 1'b0);
    wait_issue(ADD_R4, 10, k, fr);
    chk("waw_latency", 32'(k), 32'(K_LOAD));

    // Reset mid-operation discards pending writes.
    apply_reset();
    drive_cycle(1'b1, ADD_R1, 1'b0);
    apply_reset();
    drive_cycle(1'b1, ADD_R4, 1'b0);
    chk("post_reset_ready", 32'(rdy_seen), 32'd1);
    chk("post_reset_issue", 32'(issue_valid), 32'd1);

    // Random traffic against the model.
    apply_reset();
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2;
    ops[3] = 4'hB; ops[4] = 4'hC; ops[5] = 4'hF;
    for (int i = 0; i < 2000; i++) begin
      op = ops[$urandom_range(0, 5)];
      drive_cycle($urandom_range(0, 3) != 0,
                  {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom)},
                  $urandom_range(0, 9) == 0);
    end

    wait (sat_done);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
